// File: rtl/neuron_writeback_pkg.sv
// rtl/neuron_writeback_pkg.sv - shared state encoding and activation limits for neuron_writeback
package neuron_writeback_pkg;

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        DRAIN  = 2'd1,
        DONE   = 2'd2
    } wb_state_t;

    localparam int SAT_MAX     = 127;
    localparam int SAT_MIN     = -128;
    localparam int LEAKY_SHIFT = 3;

endpackage

// File: rtl/neuron_writeback_if.sv
// rtl/neuron_writeback_if.sv - accumulator input and neuron RAM write bundle for neuron_writeback
interface neuron_writeback_if #(
    parameter int ACC_W  = 16,
    parameter int ADDR_W = 8
);
    logic                     acc_valid;
    logic                     acc_ready;
    logic signed [ACC_W-1:0]  acc_data;
    logic [ADDR_W-1:0]        acc_addr;
    logic                     layer_done;
    logic                     ram_busy;
    logic                     ram_wre;
    logic [ADDR_W-1:0]        ram_waddr;
    logic [7:0]               ram_wdata;
    logic                     layer_written;
    logic [ADDR_W-1:0]        neuron_count;

    modport master (
        output acc_valid, acc_data, acc_addr, layer_done, ram_busy,
        input  acc_ready, ram_wre, ram_waddr, ram_wdata, layer_written, neuron_count
    );

    modport slave (
        input  acc_valid, acc_data, acc_addr, layer_done, ram_busy,
        output acc_ready, ram_wre, ram_waddr, ram_wdata, layer_written, neuron_count
    );
endinterface

// File: rtl/neuron_writeback_fifo.sv
// rtl/neuron_writeback_fifo.sv - synchronous FIFO with extra-bit pointers for full/empty
module neuron_writeback_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + (AW+1)'(1);
            if (pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rptr[AW-1:0]];
    assign empty = (wptr == rptr);
    // Same slot, opposite wrap bit: the writer has lapped the reader.
    assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);

endmodule

// File: rtl/neuron_writeback.sv
// rtl/neuron_writeback.sv - rescale/ReLU/saturate MAC results and drain them to neuron RAM (option: NEURON_WRITEBACK_LEAKY_RELU_EN)
module neuron_writeback
    import neuron_writeback_pkg::*;
#(
    parameter int ACC_W     = 16,
    parameter int FRAC_BITS = 4,
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 4
) (
    input  logic              clk,
    input  logic              reset,
    neuron_writeback_if.slave bus
);
    localparam logic signed [ACC_W-1:0] POS_LIM = ACC_W'(SAT_MAX);

    wb_state_t           state, state_n;
    logic                accept_ok;
    logic                done_pulse;
    logic signed [ACC_W-1:0] scaled;
    logic [7:0]          act_val;
    logic                push, pop, fifo_full, fifo_empty;
    logic [ADDR_W+7:0]   head;
    logic                wre_q;
    logic [ADDR_W-1:0]   waddr_q;
    logic [7:0]          wdata_q;
    logic [ADDR_W-1:0]   count_q;

`ifdef NEURON_WRITEBACK_LEAKY_RELU_EN
    localparam logic signed [ACC_W-1:0] NEG_LIM = ACC_W'(SAT_MIN);
    logic signed [ACC_W-1:0] leaky;
`endif

    always_comb begin
        scaled  = bus.acc_data >>> FRAC_BITS;
        act_val = scaled[7:0];
`ifdef NEURON_WRITEBACK_LEAKY_RELU_EN
        leaky   = scaled >>> LEAKY_SHIFT;
`endif
        if (scaled > POS_LIM) begin
            act_val = 8'(SAT_MAX);
        end else if (scaled[ACC_W-1]) begin
`ifdef NEURON_WRITEBACK_LEAKY_RELU_EN
            act_val = (leaky < NEG_LIM) ? 8'(SAT_MIN) : leaky[7:0];
`else
            act_val = 8'd0;
`endif
        end
    end

    assign push = bus.acc_valid && bus.acc_ready;
    assign pop  = !fifo_empty && !bus.ram_busy;

    neuron_writeback_fifo #(
        .WIDTH (ADDR_W + 8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata ({bus.acc_addr, act_val}),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ACCEPT;
        else       state <= state_n;
    end

    // Draining finishes on FIFO empty alone: the last pop's write is already on the RAM port.
    always_comb begin
        state_n    = state;
        accept_ok  = 1'b0;
        done_pulse = 1'b0;
        case (state)
            ACCEPT: begin
                accept_ok = !fifo_full;
                if (bus.layer_done) state_n = DRAIN;
            end
            DRAIN:   if (fifo_empty) state_n = DONE;
            DONE: begin
                done_pulse = 1'b1;
                state_n    = ACCEPT;
            end
            default: state_n = ACCEPT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wre_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            count_q <= '0;
        end else begin
            wre_q <= pop;
            if (pop) begin
                waddr_q <= head[ADDR_W+7:8];
                wdata_q <= head[7:0];
            end
            if (state == DONE)  count_q <= '0;
            else if (pop)       count_q <= count_q + ADDR_W'(1);
        end
    end

    assign bus.acc_ready     = accept_ok && !reset;
    assign bus.layer_written = done_pulse;
    assign bus.ram_wre       = wre_q;
    assign bus.ram_waddr     = waddr_q;
    assign bus.ram_wdata     = wdata_q;
    assign bus.neuron_count  = count_q;

endmodule

// File: tb/tb_neuron_writeback.sv
// tb/tb_neuron_writeback.sv - scoreboard bench for neuron_writeback with randomized results
module tb_neuron_writeback;
    localparam int ACC_W = 16, FRAC_BITS = 4, ADDR_W = 8, DEPTH = 4;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    neuron_writeback_if #(.ACC_W(ACC_W), .ADDR_W(ADDR_W)) bus ();

    neuron_writeback #(
        .ACC_W(ACC_W), .FRAC_BITS(FRAC_BITS), .ADDR_W(ADDR_W), .DEPTH(DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   n_cmp = 0, n_bad = 0;
    exp_t sbq[$];
    int   wstamp[$];
    int   cyc = 0, writes = 0, lw_pulses = 0, lw_cyc = -1, last_w_cyc = -1;
    int   exp_count = 0, done_count = -1;
    exp_t mon_e;
    bit   busy_stop;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int floor_shift(input int v, input int sh);
        int d = 1 << sh;
        if (v >= 0) return v / d;
        return -((-v + d - 1) / d);
    endfunction

    function automatic logic [7:0] act_model(input int acc);
        int s = floor_shift(acc, FRAC_BITS);
        if (s > 127) return 8'd127;
        if (s >= 0)  return s[7:0];
`ifdef NEURON_WRITEBACK_LEAKY_RELU_EN
        s = floor_shift(s, 3);
        if (s < -128) s = -128;
        return s[7:0];
`else
        return 8'd0;
`endif
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: pops the scoreboard whenever the RAM port writes.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            exp_count = 0;
        end else begin
            if (bus.ram_wre) begin
                writes++;
                wstamp.push_back(cyc);
                last_w_cyc = cyc;
                exp_count  = (exp_count + 1) % (1 << ADDR_W);
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: got write to %0h expected none", bus.ram_waddr);
                end else begin
                    mon_e = sbq.pop_front();
                    check("waddr", 32'(bus.ram_waddr), 32'(mon_e.addr));
                    check("wdata", 32'(bus.ram_wdata), 32'(mon_e.data));
                end
                check("neuron_count", 32'(bus.neuron_count), 32'(exp_count));
            end
            if (bus.layer_written) begin
                lw_pulses++;
                lw_cyc     = cyc;
                done_count = int'(bus.neuron_count);
                check("count_at_done", 32'(bus.neuron_count), 32'(exp_count));
                exp_count = 0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [15:0] d, input logic [7:0] a, input bit ld,
                         input int max_wait, output bit ok);
        exp_t e;
        bus.acc_valid  = 1'b1;
        bus.acc_data   = d;
        bus.acc_addr   = a;
        bus.layer_done = ld;
        ok = 1'b0;
        for (int i = 0; i < max_wait; i++) begin
            @(negedge clk);
            if (bus.acc_ready) begin
                ok     = 1'b1;
                e.addr = a;
                e.data = act_model(int'($signed(d)));
                sbq.push_back(e);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.acc_valid  = 1'b0;
        bus.layer_done = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sbq.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        check(name, 32'(done), 32'd1);
        tick();
        tick();
    endtask

    initial begin
        bit ok;
        int w0, lw0;
        bus.acc_valid  = 1'b0;
        bus.acc_data   = '0;
        bus.acc_addr   = '0;
        bus.layer_done = 1'b0;
        bus.ram_busy   = 1'b0;
        busy_stop      = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_wre", 32'(bus.ram_wre), 32'd0);
        check("rst_count", 32'(bus.neuron_count), 32'd0);
        check("rst_lw", 32'(bus.layer_written), 32'd0);
        check("rst_ready", 32'(bus.acc_ready), 32'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(bus.acc_ready), 32'd1);
        tick();

        // Basic write and two-cycle latency
        offer(16'h0150, 8'd5, 1'b0, 4, ok);
        check("basic_accept", 32'(ok), 32'd1);
        @(negedge clk);
        check("lat1_wre", 32'(bus.ram_wre), 32'd0);
        @(negedge clk);
        check("lat2_wre", 32'(bus.ram_wre), 32'd1);
        check("lat2_waddr", 32'(bus.ram_waddr), 32'd5);
        check("lat2_wdata", 32'(bus.ram_wdata), 32'h15);
        check("lat2_count", 32'(bus.neuron_count), 32'd1);
        wait_drain("basic_drain");

        // Clamping corners
        offer(16'h7FF0, 8'd6, 1'b0, 4, ok);
        offer(16'hFFE0, 8'd7, 1'b0, 4, ok);
        offer(16'h8000, 8'd8, 1'b0, 4, ok);
        offer(16'h07F0, 8'd9, 1'b0, 4, ok);
        offer(16'h0800, 8'd10, 1'b0, 4, ok);
        wait_drain("clamp_drain");

        // Random results with random RAM backpressure
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    offer(16'($urandom), 8'($urandom), 1'b0, 40, ok);
                    check("rand_accept", 32'(ok), 32'd1);
                end
                busy_stop = 1'b1;
            end
            begin
                while (!busy_stop) begin
                    @(posedge clk);
                    #1;
                    bus.ram_busy = ($urandom_range(0, 3) == 0);
                end
                bus.ram_busy = 1'b0;
            end
        join
        wait_drain("rand_drain");

        // Backpressure: four fill the FIFO, the fifth stalls
        bus.ram_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(16'($urandom), 8'(20 + i), 1'b0, 1, ok);
            check("bp_accept", 32'(ok), 32'd1);
        end
        w0 = writes;
        bus.acc_valid = 1'b1;
        bus.acc_data  = 16'h0333;
        bus.acc_addr  = 8'd24;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_ready_low", 32'(bus.acc_ready), 32'd0);
            check("bp_no_write", 32'(writes), 32'(w0));
        end
        tick();
        wstamp.delete();
        bus.ram_busy = 1'b0;
        offer(16'h0333, 8'd24, 1'b0, 10, ok);
        check("bp_fifth_accept", 32'(ok), 32'd1);
        wait_drain("bp_drain");
        check("bp_nwrites", 32'(wstamp.size()), 32'd5);
        if (wstamp.size() >= 4)
            for (int k = 1; k < 4; k++)
                check("bp_consecutive", 32'(wstamp[k] - wstamp[0]), 32'(k));

        // Empty layer_done: DONE two cycles later, no writes
        w0  = writes;
        lw0 = lw_pulses;
        bus.layer_done = 1'b1;
        @(negedge clk);
        check("empty_lw_c0", 32'(bus.layer_written), 32'd0);
        tick();
        bus.layer_done = 1'b0;
        @(negedge clk);
        check("empty_lw_c1", 32'(bus.layer_written), 32'd0);
        @(negedge clk);
        check("empty_lw_c2", 32'(bus.layer_written), 32'd1);
        @(negedge clk);
        check("empty_count_clr", 32'(bus.neuron_count), 32'd0);
        check("empty_no_write", 32'(writes), 32'(w0));
        check("empty_lw_once", 32'(lw_pulses - lw0), 32'd1);
        tick();

        // Layer end: three results, layer_done with the third
        lw0 = lw_pulses;
        offer(16'($urandom), 8'd40, 1'b0, 4, ok);
        offer(16'($urandom), 8'd41, 1'b0, 4, ok);
        offer(16'($urandom), 8'd42, 1'b1, 4, ok);
        check("layer_accept3", 32'(ok), 32'd1);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("layer_ready_low", 32'(bus.acc_ready), 32'd0);
            if (bus.layer_written) begin
                ok = 1'b1;
                break;
            end
        end
        check("layer_written_seen", 32'(ok), 32'd1);
        @(negedge clk);
        check("layer_ready_back", 32'(bus.acc_ready), 32'd1);
        check("layer_count_clr", 32'(bus.neuron_count), 32'd0);
        check("layer_count_at_done", 32'(done_count), 32'd3);
        check("layer_lw_timing", 32'(lw_cyc - last_w_cyc), 32'd1);
        repeat (4) @(negedge clk);
        check("layer_lw_once", 32'(lw_pulses - lw0), 32'd1);
        check("layer_sb_empty", 32'(sbq.size()), 32'd0);
        tick();

        // Mid-operation reset discards queued entries
        bus.ram_busy = 1'b1;
        offer(16'h0150, 8'd50, 1'b0, 2, ok);
        offer(16'h0260, 8'd51, 1'b0, 2, ok);
        w0 = writes;
        reset = 1'b1;
        sbq.delete();
        tick();
        tick();
        reset = 1'b0;
        bus.ram_busy = 1'b0;
        @(negedge clk);
        check("mrst_ready", 32'(bus.acc_ready), 32'd1);
        check("mrst_count", 32'(bus.neuron_count), 32'd0);
        check("mrst_wre", 32'(bus.ram_wre), 32'd0);
        repeat (6) @(negedge clk);
        check("mrst_no_write", 32'(writes), 32'(w0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
